tz80_bus_resp: RTL and testbench
================================

# tz80_bus_resp

Memory/I-O responder for the tz80 CPU bus: it answers the core's address/we/o_data requests and drives the core's `i_data` and `locked` inputs. RAM reads go to a synchronous block RAM with 1-cycle read latency, hidden behind `locked` wait states and a 1-entry hold register. One 256-byte page is routed to an external peripheral port with a req/ack handshake and a timeout. It sits between the core and the on-chip RAM/peripheral fabric.

## Interface
- IO_PAGE, 8'hFF: `address[15:8]` value selecting the I/O window.
- IO_TIMEOUT, 64: cycles `io_req` may stay unacknowledged before forced completion.
- clock  in  1  system clock; all logic on posedge.
- resetn  in  1  reset, synchronous, active-low.
- address  in  16  CPU bus address.
- wdata  in  8  CPU write data (core `o_data`).
- we  in  1  CPU write strobe.
- rdata  out  8  read data to core `i_data`.
- locked  out  1  1 = current bus cycle completes at this edge; 0 = core stalls.
- ram_addr  out  16  RAM address.
- ram_wdata  out  8  RAM write data.
- ram_we  out  1  RAM write enable.
- ram_rdata  in  8  RAM read data, valid 1 cycle after `ram_addr` is presented.
- io_req  out  1  peripheral request, held until ack or timeout.
- io_we  out  1  peripheral write, 1 = write; valid with `io_req`.
- io_addr  out  8  `address[7:0]`, registered at request.
- io_wdata  out  8  write data, registered at request.
- io_rdata  in  8  peripheral read data, sampled with `io_ack`.
- io_ack  in  1  1-cycle completion pulse.
- io_fault  out  1  sticky: an I/O access timed out.

## Operation
- Region: I/O when `address[15:8]==IO_PAGE`, otherwise RAM.
- States: IDLE, RAM_RD, IO_WAIT, IO_DONE.
- Hold register: `hold_data`, `hold_tag[15:0]`, `hold_valid`. It caches RAM reads only.
- IDLE, RAM read:
  - Hit (`hold_valid && address==hold_tag`): `locked=1`, `rdata=hold_data`.
  - Miss: `locked=0`; drive `ram_addr=address`; latch `pend_addr`; go to RAM_RD.
- RAM_RD:
  - `rdata=ram_rdata`.
  - If `address==pend_addr`: `locked=1`; load the hold register (`tag=pend_addr`); go to IDLE.
  - Otherwise: `locked=0`; re-issue for the new address; stay in RAM_RD.
- IDLE, RAM write:
  - `locked=1` combinationally.
  - `ram_we=1`, `ram_addr=address`, `ram_wdata=wdata`.
  - If `address==hold_tag`, `hold_data<=wdata`, so the hold register stays coherent.
  - Exactly one `ram_we` per locked write cycle.
- IDLE, I/O access (read or write):
  - `locked=0`.
  - Register `io_addr`, `io_we`, `io_wdata`; assert `io_req` next cycle.
  - Go to IO_WAIT; clear the timeout counter.
- IO_WAIT:
  - `locked=0`; counter increments each cycle.
  - On `io_ack`: drop `io_req`; capture `io_rdata`; go to IO_DONE.
  - On counter==IO_TIMEOUT with no ack: drop `io_req`; capture 8'hFF; set `io_fault`; go to IO_DONE.
  - If `io_ack` and timeout coincide, ack wins; `io_fault` is not set.
- IO_DONE:
  - `locked=1`; `rdata` = captured byte; go to IDLE.
  - I/O data is never cached; `hold_valid` is unaffected.
- `rdata` outside the cases above = `hold_data`, so it is never X.
- `ram_we`, `io_req` are never asserted together.

## Timing
- Reset values: `locked=0`, `rdata=8'h00`, `ram_we=0`, `io_req=0`, `io_we=0`, `io_addr=0`, `io_wdata=0`, `io_fault=0`, state IDLE, `hold_valid=0`.
- Latencies:
  - RAM read hit: 0 wait cycles.
  - RAM read miss: 1 wait cycle (2 clocks per sequential fetch).
  - RAM write: 0 wait cycles.
  - I/O: `io_req` rises 1 cycle after the request; ack at cycle k after `io_req` rises gives `locked=1` at cycle k+1.
- Timeout: `io_req` high for at most IO_TIMEOUT cycles.
- Reset mid-operation (resetn low at any edge):
  - Next cycle: `io_req` dropped; pending RAM/I/O transaction abandoned; hold invalidated.
  - A late `io_ack` in IDLE is ignored.
- `locked` is combinational from state/address/we; it has no combinational path from `io_ack`.

## Structure
- Package `tz80_bus_pkg`:
  - state enum {IDLE, RAM_RD, IO_WAIT, IO_DONE}.
  - `TZ80_IO_FILL = 8'hFF`.
  - default `IO_PAGE`.
- Single module; no sub-module. The timeout counter is `$clog2(IO_TIMEOUT+1)` bits, inline.

## Test plan
- Read 16'h0100 (RAM holds 8'h3E), hold empty -> `locked=0` one cycle, then `locked=1` with `rdata=8'h3E`; same address again -> `locked=1` immediately.
- Write 8'h55 to 16'h0100 after caching it -> single `ram_we` pulse with `ram_wdata=8'h55`, 0 waits; subsequent read returns 8'h55 with no wait.
- I/O read 16'hFF10, peripheral acks 3 cycles after `io_req` with 8'hA7 -> `io_addr=8'h10`, `io_we=0`; `locked=1` one cycle after ack with `rdata=8'hA7`; re-read issues a new `io_req`.
- I/O write 16'hFF20 = 8'h99, never acked, IO_TIMEOUT=64 -> `io_req` high exactly 64 cycles; then `locked=1` once and `io_fault=1` sticky.
- `resetn` low for one cycle during IO_WAIT -> `io_req=0`, `io_fault=0`, `locked=0`, state IDLE; a stray `io_ack` afterwards produces no `locked` pulse.
- Address changes while in RAM_RD (16'h0200 -> 16'h0300) -> no `locked` for 16'h0200; RAM_RD re-issued for 16'h0300; `locked=1` with its data one cycle later.

Source files
------------

// File: rtl/tz80_bus_resp_pkg.sv
// Shared types and defaults for the tz80 bus responder: FSM state encoding,
// the fill byte returned on an I/O timeout, and the default I/O window/timeout.
package tz80_bus_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RAM_RD  = 2'd1,
      IO_WAIT = 2'd2,
      IO_DONE = 2'd3
   } tz80_state_e;

   localparam logic [7:0] TZ80_IO_FILL    = 8'hFF;
   localparam logic [7:0] TZ80_IO_PAGE    = 8'hFF;
   localparam int         TZ80_IO_TIMEOUT = 64;

   function automatic logic isIoAddr(input logic [15:0] addr, input logic [7:0] page);
      return addr[15:8] == page;
   endfunction

endpackage

// File: rtl/tz80_bus_resp_if.sv
// CPU side of the tz80 bus: the core drives address/data/strobe and the
// responder returns read data plus the cycle-complete flag.
interface tz80_bus_resp_if;

   logic [15:0] address;
   logic [7:0]  wdata;
   logic        we;
   logic [7:0]  rdata;
   logic        locked;

   modport master (output address, wdata, we, input rdata, locked);
   modport slave  (input address, wdata, we, output rdata, locked);

endinterface

// File: rtl/tz80_bus_resp.sv
// Memory/I-O responder for the tz80 core: block-RAM reads behind a one-entry
// hold register, zero-wait writes, and one paged peripheral window with timeout.
module tz80_bus_resp
   import tz80_bus_pkg::*;
#(
   parameter logic [7:0] IO_PAGE    = TZ80_IO_PAGE,
   parameter int         IO_TIMEOUT = TZ80_IO_TIMEOUT
) (
   input  logic            clock,
   input  logic            resetn,
   tz80_bus_resp_if.slave  cpu,
   output logic [15:0]     ram_addr,
   output logic [7:0]      ram_wdata,
   output logic            ram_we,
   input  logic [7:0]      ram_rdata,
   output logic            io_req,
   output logic            io_we,
   output logic [7:0]      io_addr,
   output logic [7:0]      io_wdata,
   input  logic [7:0]      io_rdata,
   input  logic            io_ack,
   output logic            io_fault
);

   localparam logic [1:0] S_IDLE    = IDLE;
   localparam logic [1:0] S_RAM_RD  = RAM_RD;
   localparam logic [1:0] S_IO_WAIT = IO_WAIT;
   localparam logic [1:0] S_IO_DONE = IO_DONE;
   localparam int         TW        = $clog2(IO_TIMEOUT + 1);

   logic [1:0]    r_state;
   logic [15:0]   r_pendAddr;
   logic [7:0]    r_holdData;
   logic [15:0]   r_holdTag;
   logic          r_holdValid;
   logic          r_ioReq;
   logic          r_ioWe;
   logic [7:0]    r_ioAddr;
   logic [7:0]    r_ioWdata;
   logic [7:0]    r_ioData;
   logic          r_ioFault;
   logic [TW-1:0] r_timer;

   logic          w_isIo;
   logic          w_hit;
   logic          w_pendMatch;
   logic          w_locked;
   logic          w_ramWe;
   logic [7:0]    w_rdata;
   logic [TW-1:0] w_timerNext;

   assign w_isIo      = isIoAddr(cpu.address, IO_PAGE);
   assign w_hit       = r_holdValid && (cpu.address == r_holdTag);
   assign w_pendMatch = (cpu.address == r_pendAddr) && !cpu.we;
   assign w_timerNext = r_timer + TW'(1);

   // locked and rdata depend only on state, address, we and registered data
   always_comb begin
      w_locked = 1'b0;
      w_ramWe  = 1'b0;
      w_rdata  = r_holdData;
      case (r_state)
         S_IDLE: begin
            if (!w_isIo) begin
               if (cpu.we) begin
                  w_locked = 1'b1;
                  w_ramWe  = 1'b1;
               end else if (w_hit) begin
                  w_locked = 1'b1;
               end
            end
         end
         S_RAM_RD: begin
            w_rdata  = ram_rdata;
            w_locked = w_pendMatch;
         end
         S_IO_DONE: begin
            w_locked = 1'b1;
            w_rdata  = r_ioData;
         end
         default: ;
      endcase
   end

   assign cpu.locked = resetn && w_locked;
   assign cpu.rdata  = w_rdata;
   assign ram_we     = resetn && w_ramWe;
   assign ram_addr   = cpu.address;
   assign ram_wdata  = cpu.wdata;
   assign io_req     = r_ioReq;
   assign io_we      = r_ioWe;
   assign io_addr    = r_ioAddr;
   assign io_wdata   = r_ioWdata;
   assign io_fault   = r_ioFault;

   // Main FSM; a RAM_RD whose address turns into a write or an I/O access
   // falls back to IDLE so that request is decoded afresh instead of dropped.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         r_state     <= S_IDLE;
         r_pendAddr  <= '0;
         r_holdData  <= '0;
         r_holdTag   <= '0;
         r_holdValid <= 1'b0;
         r_ioReq     <= 1'b0;
         r_ioWe      <= 1'b0;
         r_ioAddr    <= '0;
         r_ioWdata   <= '0;
         r_ioData    <= '0;
         r_ioFault   <= 1'b0;
         r_timer     <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_isIo) begin
                  r_ioAddr  <= cpu.address[7:0];
                  r_ioWe    <= cpu.we;
                  r_ioWdata <= cpu.wdata;
                  r_ioReq   <= 1'b1;
                  r_timer   <= '0;
                  r_state   <= S_IO_WAIT;
               end else if (cpu.we) begin
                  if (cpu.address == r_holdTag) begin
                     r_holdData <= cpu.wdata;
                  end
               end else if (!w_hit) begin
                  r_pendAddr <= cpu.address;
                  r_state    <= S_RAM_RD;
               end
            end
            S_RAM_RD: begin
               if (w_pendMatch) begin
                  r_holdData  <= ram_rdata;
                  r_holdTag   <= r_pendAddr;
                  r_holdValid <= 1'b1;
                  r_state     <= S_IDLE;
               end else if (!w_isIo && !cpu.we) begin
                  r_pendAddr <= cpu.address;
               end else begin
                  r_state <= S_IDLE;
               end
            end
            S_IO_WAIT: begin
               if (io_ack) begin
                  r_ioReq  <= 1'b0;
                  r_ioData <= io_rdata;
                  r_state  <= S_IO_DONE;
               end else if (w_timerNext == TW'(IO_TIMEOUT)) begin
                  r_ioReq   <= 1'b0;
                  r_ioData  <= TZ80_IO_FILL;
                  r_ioFault <= 1'b1;
                  r_state   <= S_IO_DONE;
               end else begin
                  r_timer <= w_timerNext;
               end
            end
            S_IO_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tz80_bus_resp.sv
// Self-checking bench for tz80_bus_resp: directed scenarios followed by random
// transactions scored against a transaction-level model of latency and data.
module tb_tz80_bus_resp;

   logic        clock;
   logic        resetn;
   logic [15:0] ramAddr;
   logic [7:0]  ramWdata;
   logic        ramWe;
   logic [7:0]  ramRdata;
   logic        ioReq;
   logic        ioWe;
   logic [7:0]  ioAddr;
   logic [7:0]  ioWdata;
   logic [7:0]  ioRdata;
   logic        ioAck;
   logic        ioFault;

   logic [7:0]  mem [0:65535];

   int          errors = 0;
   int          checks = 0;

   int          obsWaits;
   int          obsReqCycles;
   int          obsWeCount;
   logic [7:0]  obsLockData;
   logic [7:0]  obsWdata;
   logic [7:0]  obsIoAddr;
   logic        obsIoWe;
   logic [7:0]  obsIoWdata;
   logic        txnDone;
   logic        anyOverlap;

   logic [15:0] poolAddr [8];
   logic [7:0]  refMem   [8];
   logic [15:0] mTag;
   logic        mValid;

   tz80_bus_resp_if bus ();

   tz80_bus_resp dut (
      .clock     (clock),
      .resetn    (resetn),
      .cpu       (bus),
      .ram_addr  (ramAddr),
      .ram_wdata (ramWdata),
      .ram_we    (ramWe),
      .ram_rdata (ramRdata),
      .io_req    (ioReq),
      .io_we     (ioWe),
      .io_addr   (ioAddr),
      .io_wdata  (ioWdata),
      .io_rdata  (ioRdata),
      .io_ack    (ioAck),
      .io_fault  (ioFault)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Synchronous block RAM with one cycle of read latency
   always @(posedge clock) begin
      if (ramWe) mem[ramAddr] <= ramWdata;
      ramRdata <= mem[ramAddr];
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: observed no finish expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // One bus transaction from a negedge until the cycle that completes it;
   // the peripheral acks ackDelay cycles after io_req rises (-1 = never).
   task automatic applyStimulus(input logic [15:0] addr, input logic [7:0] data, input logic wr,
                                input int ackDelay, input logic [7:0] ackData);
      bus.address  = addr;
      bus.wdata    = data;
      bus.we       = wr;
      obsWaits     = 0;
      obsReqCycles = 0;
      obsWeCount   = 0;
      obsLockData  = 8'h00;
      txnDone      = 1'b0;
      for (int cyc = 0; cyc < 300 && !txnDone; cyc++) begin
         #1;
         if (ramWe) begin
            obsWeCount++;
            obsWdata = ramWdata;
         end
         if (ramWe && ioReq) anyOverlap = 1'b1;
         if (ioReq) begin
            if (obsReqCycles == 0) begin
               obsIoAddr  = ioAddr;
               obsIoWe    = ioWe;
               obsIoWdata = ioWdata;
            end
            if (obsReqCycles == ackDelay) begin
               ioAck   = 1'b1;
               ioRdata = ackData;
            end
            obsReqCycles++;
         end
         if (bus.locked) begin
            obsLockData = bus.rdata;
            txnDone     = 1'b1;
         end else begin
            obsWaits++;
         end
         @(posedge clock);
         @(negedge clock);
         ioAck = 1'b0;
      end
      checkOutput("txn_complete", 32'(txnDone), 32'd1);
   endtask

   initial begin
      bus.address = 16'h0000;
      bus.wdata   = 8'h00;
      bus.we      = 1'b0;
      ioAck       = 1'b0;
      ioRdata     = 8'h00;
      anyOverlap  = 1'b0;
      resetn      = 1'b0;
      poolAddr    = '{16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h1234, 16'hFE00, 16'h00FF, 16'h8000};
      refMem      = '{8'h3E, 8'h11, 8'h22, 8'h44, 8'h5A, 8'h0F, 8'hC3, 8'h77};

      repeat (2) @(posedge clock);
      @(negedge clock);
      #1;
      checkOutput("rst_locked",  32'(bus.locked), 32'd0);
      checkOutput("rst_rdata",   32'(bus.rdata),  32'h00);
      checkOutput("rst_ram_we",  32'(ramWe),      32'd0);
      checkOutput("rst_io_req",  32'(ioReq),      32'd0);
      checkOutput("rst_io_we",   32'(ioWe),       32'd0);
      checkOutput("rst_io_addr", 32'(ioAddr),     32'h00);
      checkOutput("rst_io_wd",   32'(ioWdata),    32'h00);
      checkOutput("rst_fault",   32'(ioFault),    32'd0);
      @(negedge clock);
      resetn = 1'b1;

      $display("[TB] preloading RAM through the bus");
      for (int i = 0; i < 8; i++) begin
         applyStimulus(poolAddr[i], refMem[i], 1'b1, -1, 8'h00);
         checkOutput("pre_waits", 32'(obsWaits),   32'd0);
         checkOutput("pre_we",    32'(obsWeCount), 32'd1);
      end

      $display("[TB] RAM read miss then hit");
      applyStimulus(16'h0100, 8'h00, 1'b0, -1, 8'h00);
      checkOutput("miss_waits", 32'(obsWaits),    32'd1);
      checkOutput("miss_data",  32'(obsLockData), 32'h3E);
      applyStimulus(16'h0100, 8'h00, 1'b0, -1, 8'h00);
      checkOutput("hit_waits",  32'(obsWaits),    32'd0);
      checkOutput("hit_data",   32'(obsLockData), 32'h3E);

      $display("[TB] write to cached address");
      applyStimulus(16'h0100, 8'h55, 1'b1, -1, 8'h00);
      checkOutput("wr_waits", 32'(obsWaits),   32'd0);
      checkOutput("wr_count", 32'(obsWeCount), 32'd1);
      checkOutput("wr_data",  32'(obsWdata),   32'h55);
      refMem[0] = 8'h55;
      applyStimulus(16'h0100, 8'h00, 1'b0, -1, 8'h00);
      checkOutput("coh_waits", 32'(obsWaits),    32'd0);
      checkOutput("coh_data",  32'(obsLockData), 32'h55);

      $display("[TB] I/O read with ack after 3 cycles");
      applyStimulus(16'hFF10, 8'h00, 1'b0, 3, 8'hA7);
      checkOutput("ior_addr",  32'(obsIoAddr),    32'h10);
      checkOutput("ior_we",    32'(obsIoWe),      32'd0);
      checkOutput("ior_req",   32'(obsReqCycles), 32'd4);
      checkOutput("ior_waits", 32'(obsWaits),     32'd5);
      checkOutput("ior_data",  32'(obsLockData),  32'hA7);
      applyStimulus(16'hFF10, 8'h00, 1'b0, 3, 8'h5C);
      checkOutput("ior2_req",  32'(obsReqCycles), 32'd4);
      checkOutput("ior2_data", 32'(obsLockData),  32'h5C);

      $display("[TB] I/O write with no ack");
      applyStimulus(16'hFF20, 8'h99, 1'b1, -1, 8'h00);
      checkOutput("tmo_req",   32'(obsReqCycles), 32'd64);
      checkOutput("tmo_waits", 32'(obsWaits),     32'd65);
      checkOutput("tmo_data",  32'(obsLockData),  32'hFF);
      checkOutput("tmo_we",    32'(obsIoWe),      32'd1);
      checkOutput("tmo_wd",    32'(obsIoWdata),   32'h99);
      checkOutput("tmo_fault", 32'(ioFault),      32'd1);
      applyStimulus(16'h0100, 8'h00, 1'b0, -1, 8'h00);
      checkOutput("post_io_hit", 32'(obsWaits), 32'd0);
      checkOutput("fault_stick", 32'(ioFault),  32'd1);

      $display("[TB] reset during IO_WAIT");
      bus.address = 16'hFF30;
      bus.we      = 1'b0;
      #1;
      checkOutput("rio_req_lock", 32'(bus.locked), 32'd0);
      @(posedge clock);
      @(negedge clock);
      #1;
      checkOutput("rio_req_up", 32'(ioReq), 32'd1);
      resetn = 1'b0;
      @(posedge clock);
      @(negedge clock);
      resetn = 1'b1;
      ioAck  = 1'b1;
      ioRdata = 8'h3C;
      #1;
      checkOutput("rio_req_dn", 32'(ioReq),      32'd0);
      checkOutput("rio_fault",  32'(ioFault),    32'd0);
      checkOutput("rio_locked", 32'(bus.locked), 32'd0);
      @(posedge clock);
      @(negedge clock);
      ioAck = 1'b0;
      #1;
      checkOutput("stray_ack_lock", 32'(bus.locked), 32'd0);
      checkOutput("stray_ack_req",  32'(ioReq),      32'd1);
      resetn      = 1'b0;
      bus.address = 16'h0100;
      @(posedge clock);
      @(negedge clock);
      resetn = 1'b1;
      applyStimulus(16'h0100, 8'h00, 1'b0, -1, 8'h00);
      checkOutput("inval_waits", 32'(obsWaits),    32'd1);
      checkOutput("inval_data",  32'(obsLockData), 32'h55);

      $display("[TB] address change while in RAM_RD");
      bus.address = 16'h0200;
      #1;
      checkOutput("chg_lock0", 32'(bus.locked), 32'd0);
      @(posedge clock);
      @(negedge clock);
      bus.address = 16'h0300;
      #1;
      checkOutput("chg_lock1", 32'(bus.locked), 32'd0);
      @(posedge clock);
      @(negedge clock);
      #1;
      checkOutput("chg_lock2", 32'(bus.locked), 32'd1);
      checkOutput("chg_data",  32'(bus.rdata),  32'h22);
      @(posedge clock);
      @(negedge clock);
      mTag   = 16'h0300;
      mValid = 1'b1;

      $display("[TB] random transactions");
      for (int t = 0; t < 40; t++) begin
         int          op;
         int          idx;
         int          k;
         logic [7:0]  d;
         logic [7:0]  ackD;
         logic [15:0] ioA;
         op   = $urandom_range(0, 3);
         idx  = $urandom_range(0, 7);
         k    = $urandom_range(0, 6);
         d    = 8'($urandom);
         ackD = 8'($urandom);
         ioA  = {8'hFF, 8'($urandom)};
         case (op)
            0: begin
               applyStimulus(poolAddr[idx], 8'h00, 1'b0, -1, 8'h00);
               checkOutput("rnd_rd_waits", 32'(obsWaits),
                           (mValid && mTag == poolAddr[idx]) ? 32'd0 : 32'd1);
               checkOutput("rnd_rd_data", 32'(obsLockData), 32'(refMem[idx]));
               mTag   = poolAddr[idx];
               mValid = 1'b1;
            end
            1: begin
               applyStimulus(poolAddr[idx], d, 1'b1, -1, 8'h00);
               checkOutput("rnd_wr_waits", 32'(obsWaits),   32'd0);
               checkOutput("rnd_wr_count", 32'(obsWeCount), 32'd1);
               checkOutput("rnd_wr_data",  32'(obsWdata),   32'(d));
               refMem[idx] = d;
            end
            default: begin
               applyStimulus(ioA, d, op == 3, k, ackD);
               checkOutput("rnd_io_waits", 32'(obsWaits),     32'(k + 2));
               checkOutput("rnd_io_req",   32'(obsReqCycles), 32'(k + 1));
               checkOutput("rnd_io_data",  32'(obsLockData),  32'(ackD));
               checkOutput("rnd_io_addr",  32'(obsIoAddr),    32'(ioA[7:0]));
               checkOutput("rnd_io_we",    32'(obsIoWe),      32'(op == 3));
               if (op == 3) checkOutput("rnd_io_wd", 32'(obsIoWdata), 32'(d));
            end
         endcase
      end
      checkOutput("we_req_overlap", 32'(anyOverlap), 32'd0);
      checkOutput("fault_final",    32'(ioFault),    32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
